// File: rtl/barrel_rotator_left_pipe_if.sv
// rtl/barrel_rotator_left_pipe_if.sv - stream bundle for the left rotator pipe; ROTATOR_LEFT_TAG_EN adds in_tag/out_tag
interface barrel_rotator_left_pipe_if #(
    parameter int INPUTWIDTH         = 32,
    parameter int OUTPUTWIDTH        = INPUTWIDTH,
    parameter int SHIFTBITS_PER_STEP = 1,
    parameter int TAGWIDTH           = 8
);
    localparam int WIDEST = (INPUTWIDTH > OUTPUTWIDTH) ? INPUTWIDTH : OUTPUTWIDTH;
    localparam int STAGES = $clog2(WIDEST / SHIFTBITS_PER_STEP);

    logic                   in_valid;
    logic                   in_ready;
    logic [INPUTWIDTH-1:0]  dataIn;
    logic [STAGES-1:0]      rotationLeft;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUTPUTWIDTH-1:0] dataOut;
`ifdef ROTATOR_LEFT_TAG_EN
    logic [TAGWIDTH-1:0]    in_tag;
    logic [TAGWIDTH-1:0]    out_tag;
`endif

    if (TAGWIDTH < 1) begin : g_bad_tagwidth
        $error("barrel_rotator_left_pipe_if: TAGWIDTH must be at least 1");
    end

    modport master (
        output in_valid, dataIn, rotationLeft, out_ready,
`ifdef ROTATOR_LEFT_TAG_EN
        output in_tag,
        input  out_tag,
`endif
        input  in_ready, out_valid, dataOut
    );

    modport slave (
        input  in_valid, dataIn, rotationLeft, out_ready,
`ifdef ROTATOR_LEFT_TAG_EN
        input  in_tag,
        output out_tag,
`endif
        output in_ready, out_valid, dataOut
    );
endinterface

// File: rtl/barrel_rotator_left_pipe.sv
// rtl/barrel_rotator_left_pipe.sv - pipelined left barrel rotator, one rotation stage per slot; ROTATOR_LEFT_TAG_EN adds tag sideband
module barrel_rotator_left_pipe #(
    parameter int INPUTWIDTH         = 32,
    parameter int OUTPUTWIDTH        = INPUTWIDTH,
    parameter int SHIFTBITS_PER_STEP = 1,
    parameter int TAGWIDTH           = 8
) (
    input logic                     clk,
    input logic                     reset,
    barrel_rotator_left_pipe_if.slave bus
);
    localparam int WIDEST = (INPUTWIDTH > OUTPUTWIDTH) ? INPUTWIDTH : OUTPUTWIDTH;
    localparam int UNITS  = WIDEST / SHIFTBITS_PER_STEP;
    localparam int STAGES = $clog2(UNITS);

    if ((WIDEST % SHIFTBITS_PER_STEP) != 0) begin : g_bad_step
        $error("barrel_rotator_left_pipe: WIDEST must be a multiple of SHIFTBITS_PER_STEP");
    end
    if ((UNITS < 2) || ((UNITS & (UNITS - 1)) != 0)) begin : g_bad_units
        $error("barrel_rotator_left_pipe: WIDEST/SHIFTBITS_PER_STEP must be a power of 2 and >= 2");
    end
    if (TAGWIDTH < 1) begin : g_bad_tagwidth
        $error("barrel_rotator_left_pipe: TAGWIDTH must be at least 1");
    end

    // Slot registers 1..STAGES; slot 0 is the input port itself.
    logic [STAGES:1]     valid_q;
    logic [WIDEST-1:0]   data_q [1:STAGES];
    logic [STAGES-1:0]   rot_q  [1:STAGES];
    logic [STAGES:1]     rdy;
    logic                any_empty;

    // Uniform view of every slot's contents, index 0 being the input port.
    logic [STAGES:0]     stage_v;
    logic [WIDEST-1:0]   stage_d [0:STAGES];
    logic [STAGES-1:0]   stage_r [0:STAGES];
    logic [WIDEST-1:0]   nxt_d   [1:STAGES];

`ifdef ROTATOR_LEFT_TAG_EN
    logic [TAGWIDTH-1:0] tag_q   [1:STAGES];
    logic [TAGWIDTH-1:0] stage_t [0:STAGES];
`endif

    // Left rotate by n bits; n is always strictly between 0 and WIDEST here.
    function automatic logic [WIDEST-1:0] rotl(input logic [WIDEST-1:0] d, input int n);
        return (d << n) | (d >> (WIDEST - n));
    endfunction

    // Ready chain: a slot can load if the output drains or any slot at or after it is empty.
    always_comb begin
        rdy       = '0;
        any_empty = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            any_empty = any_empty | ~valid_q[k];
            rdy[k]    = bus.out_ready | any_empty;
        end
    end

    // Gather input port and slot registers into one indexable view; input is zero-extended.
    always_comb begin
        stage_v    = '0;
        stage_d[0] = '0;
        stage_d[0][INPUTWIDTH-1:0] = bus.dataIn;
        stage_r[0] = bus.rotationLeft;
        stage_v[0] = bus.in_valid;
        for (int k = 1; k <= STAGES; k++) begin
            stage_v[k] = valid_q[k];
            stage_d[k] = data_q[k];
            stage_r[k] = rot_q[k];
        end
    end

`ifdef ROTATOR_LEFT_TAG_EN
    // Tag view alongside the data view.
    always_comb begin
        stage_t[0] = bus.in_tag;
        for (int k = 1; k <= STAGES; k++) begin
            stage_t[k] = tag_q[k];
        end
    end
`endif

    // Slot k conditionally rotates by 2^(k-1) steps according to rotation bit k-1.
    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            nxt_d[k] = stage_d[k-1];
            if (stage_r[k-1][k-1]) begin
                nxt_d[k] = rotl(stage_d[k-1], (1 << (k - 1)) * SHIFTBITS_PER_STEP);
            end
        end
    end

    // Pipeline slot registers: clear on reset, otherwise advance each slot that is ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                data_q[k] <= '0;
                rot_q[k]  <= '0;
`ifdef ROTATOR_LEFT_TAG_EN
                tag_q[k]  <= '0;
`endif
            end
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (rdy[k]) begin
                    valid_q[k] <= stage_v[k-1];
                    data_q[k]  <= nxt_d[k];
                    rot_q[k]   <= stage_r[k-1];
`ifdef ROTATOR_LEFT_TAG_EN
                    tag_q[k]   <= stage_t[k-1];
`endif
                end
            end
        end
    end

    assign bus.in_ready  = rdy[1] & ~reset;
    assign bus.out_valid = valid_q[STAGES];
    assign bus.dataOut   = data_q[STAGES][OUTPUTWIDTH-1:0];
`ifdef ROTATOR_LEFT_TAG_EN
    assign bus.out_tag   = tag_q[STAGES];
`endif
endmodule
